// File: rtl/param_pkg.sv
// Shared constants, slot classes and FSM states for the STM-1 frame scheduler.
package param_pkg;

    localparam int unsigned STM1_Length = 270;
    localparam int unsigned STM1_Width  = 9;
    localparam int unsigned c4_Length   = 260;

    localparam int unsigned SOH_COLS = 9;
    localparam int unsigned POH_COL  = 9;
    localparam int unsigned PTR_ROW  = 3;

    typedef enum logic [1:0] {
        SelSoh = 2'd0,
        SelPtr = 2'd1,
        SelPoh = 2'd2,
        SelC4  = 2'd3
    } byte_sel_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Payload occupies the trailing c4_Length columns of each row.
    function automatic byte_sel_e slot_class(input logic [3:0] row, input logic [8:0] col);
        if (col < 9'(SOH_COLS)) begin
            return (row == 4'(PTR_ROW)) ? SelPtr : SelSoh;
        end else if (col >= 9'(STM1_Length - c4_Length)) begin
            return SelC4;
        end else begin
            return SelPoh;
        end
    endfunction

endpackage

// File: rtl/stm1_pos_counter.sv
// Row/column position of the current STM-1 slot; wraps column, then row, then frame.
module stm1_pos_counter
    import param_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [3:0] row,
    output logic [8:0] col,
    output logic       last
);

    localparam logic [3:0] LastRow = 4'(STM1_Width - 1);
    localparam logic [8:0] LastCol = 9'(STM1_Length - 1);

    logic [3:0] row_q, row_d;
    logic [8:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_q == LastCol) begin
                col_d = '0;
                row_d = (row_q == LastRow) ? 4'd0 : row_q + 4'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == LastRow) && (col_q == LastCol);

endmodule

// File: rtl/stm1_frame_sched.sv
// STM-1 frame slot scheduler: walks the 9x270 frame, classifies each slot and
// paces C4 payload pops against downstream backpressure.
module stm1_frame_sched
    import param_pkg::*;
#(
    parameter int unsigned MAX_FRAMES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       out_ready,
    output logic       out_valid,
    input  logic       c4_valid,
    output logic       c4_rd,
    output logic [1:0] byte_sel,
    output logic [3:0] row,
    output logic [8:0] col,
    output logic [3:0] poh_idx,
    output logic       frame_start,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       busy,
    output logic       underflow
);

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic [7:0]  frame_cnt_q;
    logic        underflow_q;

    logic        active;
    logic        accept;
    logic        last;
    logic        limit_hit;
    byte_sel_e   sel;

    // Position is held at (0, 0) while idle so each run starts on a frame boundary.
    stm1_pos_counter u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == StIdle),
        .adv  (accept),
        .row  (row),
        .col  (col),
        .last (last)
    );

    assign active    = (state_q != StIdle);
    assign sel       = slot_class(row, col);
    assign out_valid = active && ((sel != SelC4) || c4_valid);
    assign accept    = out_valid && out_ready;
    assign limit_hit = (MAX_FRAMES != 0) && ((run_cnt_q + 32'd1) == MAX_FRAMES);

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        run_cnt_d = run_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d   = StRun;
                    start_d   = 1'b1;
                    run_cnt_d = '0;
                end
            end
            StRun: begin
                if (frame_done) begin
                    run_cnt_d = run_cnt_q + 32'd1;
                    if (!en || limit_hit) begin
                        state_d = StIdle;
                    end else begin
                        start_d = 1'b1;
                    end
                end else if (!en) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                if (frame_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            run_cnt_q   <= '0;
            frame_cnt_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            run_cnt_q <= run_cnt_d;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (active && (sel == SelC4) && out_ready && !c4_valid) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign byte_sel    = sel;
    assign poh_idx     = (sel == SelPoh) ? row : 4'd0;
    assign c4_rd       = accept && (sel == SelC4);
    assign frame_done  = accept && last;
    assign frame_start = start_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = active;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_stm1_frame_sched.sv
// Directed bench for stm1_frame_sched: a continuous instance and a two-frame-limited one.
module tb_stm1_frame_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, out_ready, c4_valid;
    logic       a_out_valid, a_c4_rd, a_frame_start, a_frame_done, a_busy, a_underflow;
    logic [1:0] a_byte_sel;
    logic [3:0] a_row, a_poh_idx;
    logic [8:0] a_col;
    logic [7:0] a_frame_cnt;

    logic       b_rst, b_en, b_out_ready, b_c4_valid;
    logic       b_out_valid, b_c4_rd, b_frame_start, b_frame_done, b_busy, b_underflow;
    logic [1:0] b_byte_sel;
    logic [3:0] b_row, b_poh_idx;
    logic [8:0] b_col;
    logic [7:0] b_frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    stm1_frame_sched #(.MAX_FRAMES(0)) dut (
        .clk(clk), .rst(rst), .en(en), .out_ready(out_ready), .out_valid(a_out_valid),
        .c4_valid(c4_valid), .c4_rd(a_c4_rd), .byte_sel(a_byte_sel), .row(a_row),
        .col(a_col), .poh_idx(a_poh_idx), .frame_start(a_frame_start),
        .frame_done(a_frame_done), .frame_cnt(a_frame_cnt), .busy(a_busy),
        .underflow(a_underflow)
    );

    stm1_frame_sched #(.MAX_FRAMES(2)) dut_lim (
        .clk(clk), .rst(b_rst), .en(b_en), .out_ready(b_out_ready), .out_valid(b_out_valid),
        .c4_valid(b_c4_valid), .c4_rd(b_c4_rd), .byte_sel(b_byte_sel), .row(b_row),
        .col(b_col), .poh_idx(b_poh_idx), .frame_start(b_frame_start),
        .frame_done(b_frame_done), .frame_cnt(b_frame_cnt), .busy(b_busy),
        .underflow(b_underflow)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] pos(input bit b);
        return b ? {b_row, b_col} : {a_row, a_col};
    endfunction

    task automatic wait_pos(input bit b, input int r, input int c, input string tag);
        logic [12:0] want;
        int k;
        want = {4'(r), 9'(c)};
        k = 0;
        while (pos(b) !== want && k < 6000) begin
            tick();
            k++;
        end
        chk(tag, 32'(pos(b)), 32'(want));
    endtask

    task automatic wait_done(input bit b, input string tag);
        int k;
        k = 0;
        while (!(b ? b_frame_done : a_frame_done) && k < 6000) begin
            tick();
            k++;
        end
        chk(tag, 32'(b ? b_frame_done : a_frame_done), 1);
    endtask

    initial begin
        int k, rds, acc, stalls, cyc;

        rst = 1'b1; en = 1'b0; out_ready = 1'b1; c4_valid = 1'b1;
        b_rst = 1'b1; b_en = 1'b0; b_out_ready = 1'b1; b_c4_valid = 1'b1;
        repeat (2) tick();
        chk("rst_row", a_row, 0);
        chk("rst_col", a_col, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_valid", a_out_valid, 0);
        chk("rst_c4_rd", a_c4_rd, 0);
        chk("rst_fcnt", a_frame_cnt, 0);
        chk("rst_uflow", a_underflow, 0);
        chk("rst_sel", a_byte_sel, 0);
        chk("rst_start", a_frame_start, 0);
        chk("rst_done", a_frame_done, 0);
        chk("rst_poh", a_poh_idx, 0);

        // Start: IDLE with en, then first RUN cycle.
        rst = 1'b0; en = 1'b1; #1;
        chk("idle_valid", a_out_valid, 0);
        chk("idle_busy", a_busy, 0);
        tick();
        chk("start_pulse", a_frame_start, 1);
        chk("start_busy", a_busy, 1);
        chk("start_row", a_row, 0);
        chk("start_col", a_col, 0);
        chk("start_valid", a_out_valid, 1);
        tick();
        chk("start_single", a_frame_start, 0);
        chk("adv_col", a_col, 1);

        // Slot classes.
        wait_pos(0, 0, 9, "reach_0_9");
        chk("poh_sel_0_9", a_byte_sel, 2);
        chk("poh_idx_0_9", a_poh_idx, 0);
        wait_pos(0, 3, 0, "reach_3_0");
        for (int i = 0; i < 9; i++) begin
            chk("ptr_col", a_col, i);
            chk("ptr_sel", a_byte_sel, 1);
            tick();
        end
        chk("poh_idx_3_9", a_poh_idx, 3);
        wait_pos(0, 4, 10, "reach_4_10");
        chk("c4_sel_4_10", a_byte_sel, 3);
        chk("c4_rd_4_10", a_c4_rd, 1);
        wait_pos(0, 8, 9, "reach_8_9");
        chk("poh_idx_8_9", a_poh_idx, 8);

        // Frame period and payload pops with everything held ready.
        wait_done(0, "done_f1");
        tick();
        chk("restart_pulse", a_frame_start, 1);
        chk("fcnt_1", a_frame_cnt, 1);
        k = 1; rds = 0;
        while (!a_frame_done && k < 3000) begin
            rds += int'(a_c4_rd);
            tick();
            k++;
        end
        rds += int'(a_c4_rd);
        chk("frame_period", k, 2430);
        chk("c4_pops", rds, 2340);
        tick();
        chk("fcnt_2", a_frame_cnt, 2);
        chk("restart_pulse2", a_frame_start, 1);

        // Backpressure on SOH at (0, 3) for three cycles.
        acc = 0; stalls = 0; cyc = 0;
        while (a_col != 9'd9 && cyc < 50) begin
            if (a_col == 9'd3 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                chk("stall_rd", a_c4_rd, 0);
                chk("stall_col", a_col, 3);
            end
            acc += int'(a_out_valid && out_ready);
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        chk("soh_accepts", acc, 9);
        chk("soh_cycles", cyc, 12);

        // Payload starvation at (2, 50).
        wait_pos(0, 2, 50, "reach_2_50");
        chk("uflow_before", a_underflow, 0);
        c4_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("starve_rd", a_c4_rd, 0);
            chk("starve_valid", a_out_valid, 0);
            chk("starve_pos", 32'(pos(0)), {19'd0, 4'd2, 9'd50});
            tick();
        end
        chk("uflow_set", a_underflow, 1);
        c4_valid = 1'b1; #1;
        chk("resume_rd", a_c4_rd, 1);
        tick();
        chk("resume_col", a_col, 51);

        // Stop request at (5, 100); a re-assert during FINISH must not cancel it.
        wait_pos(0, 5, 100, "reach_5_100");
        en = 1'b0;
        tick();
        chk("finish_busy", a_busy, 1);
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        wait_done(0, "done_finish");
        tick();
        chk("stop_busy", a_busy, 0);
        chk("stop_start", a_frame_start, 0);
        chk("stop_valid", a_out_valid, 0);
        chk("stop_fcnt", a_frame_cnt, 3);
        chk("uflow_sticky", a_underflow, 1);

        // en drop coinciding with the frame end.
        en = 1'b1;
        tick();
        chk("run2_start", a_frame_start, 1);
        wait_pos(0, 8, 269, "reach_8_269");
        en = 1'b0; #1;
        chk("coinc_done", a_frame_done, 1);
        tick();
        chk("coinc_busy", a_busy, 0);
        chk("coinc_start", a_frame_start, 0);
        chk("coinc_fcnt", a_frame_cnt, 4);

        // Two-frame limit, then reset mid-frame.
        b_rst = 1'b0; b_en = 1'b1;
        tick();
        chk("lim_start", b_frame_start, 1);
        wait_done(1, "lim_done1");
        tick();
        chk("lim_busy1", b_busy, 1);
        chk("lim_start1", b_frame_start, 1);
        chk("lim_fcnt1", b_frame_cnt, 1);
        wait_done(1, "lim_done2");
        tick();
        chk("lim_idle", b_busy, 0);
        chk("lim_nostart", b_frame_start, 0);
        chk("lim_fcnt2", b_frame_cnt, 2);
        tick();
        chk("lim_rerun", b_frame_start, 1);
        wait_pos(1, 7, 200, "reach_7_200");
        b_rst = 1'b1;
        tick();
        chk("mrst_row", b_row, 0);
        chk("mrst_col", b_col, 0);
        chk("mrst_busy", b_busy, 0);
        chk("mrst_valid", b_out_valid, 0);
        chk("mrst_c4_rd", b_c4_rd, 0);
        chk("mrst_start", b_frame_start, 0);
        chk("mrst_fcnt", b_frame_cnt, 0);
        chk("mrst_uflow", b_underflow, 0);
        chk("mrst_sel", b_byte_sel, 0);
        chk("mrst_poh", b_poh_idx, 0);
        for (int i = 0; i < 3; i++) begin
            chk("mrst_done", b_frame_done, 0);
            chk("mrst_hold", b_busy, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stm1_frame_sched.md
STM1_FRAME_SCHED -- requirements
Module: stm1_frame_sched

Interface
REQ-001 SHALL take parameter MAX_FRAMES, default 0, number of frames to emit per start; 0 means continuous.
REQ-002 SHALL have input clk, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 SHALL have input rst, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have input en, 1 bit, run request.
REQ-005 SHALL have input out_ready, 1 bit, downstream accepts the current slot.
REQ-006 SHALL have output out_valid, 1 bit, the current slot is presentable.
REQ-007 SHALL have input c4_valid, 1 bit, the C4 payload source has a byte available.
REQ-008 SHALL have output c4_rd, 1 bit, pop one C4 payload byte.
REQ-009 SHALL have output byte_sel, 2 bits: 0 = section overhead, 1 = AU pointer, 2 = VC4 POH, 3 = C4 payload.
REQ-010 SHALL have output row, 4 bits, current STM1 row, range 0..8.
REQ-011 SHALL have output col, 9 bits, current STM1 column, range 0..269.
REQ-012 SHALL have output poh_idx, 4 bits, POH byte index; equals row while byte_sel = 2, else 0.
REQ-013 SHALL have outputs frame_start and frame_done, 1 bit each, single-cycle pulses.
REQ-014 SHALL have output frame_cnt, 8 bits, the number of completed frames.
REQ-015 SHALL have outputs busy, 1 bit, and underflow, 1 bit, the latter sticky.

Function
REQ-016 SHALL implement states IDLE, RUN and FINISH.
REQ-017 In IDLE with en = 1, SHALL move to RUN on the next cycle at row 0, col 0, and pulse frame_start in the first RUN cycle.
REQ-018 SHALL classify each slot combinationally from (row, col):
- col < 9 and row = 3 -> byte_sel 1;
- col < 9 and any other row -> byte_sel 0;
- col = 9 -> byte_sel 2;
- col 10..269 -> byte_sel 3 (260 columns, equal to c4_Length).
REQ-019 In RUN or FINISH, out_valid SHALL be 1 for byte_sel 0..2, and SHALL equal c4_valid for byte_sel 3.
REQ-020 A slot SHALL advance only when out_valid and out_ready are both 1 in the same cycle; the advance takes effect on the next cycle (zero added latency).
REQ-021 c4_rd SHALL equal out_valid AND out_ready AND (byte_sel = 3), with exactly one pop per payload slot.
REQ-022 Slot advance order SHALL be col+1; at col 269, col wraps to 0 and row+1; at (8, 269), the position wraps to (0, 0).
REQ-023 frame_done SHALL pulse in the cycle the (8, 269) slot is accepted; frame_cnt SHALL increment in that same cycle, wrapping 255 -> 0.
REQ-024 After frame_done, SHALL pulse frame_start in the next cycle and continue, unless en = 0 or the frame limit is reached.
REQ-025 If en = 0 during RUN, SHALL move to FINISH and complete the current frame, then go to IDLE; re-asserting en during FINISH SHALL NOT cancel the stop.
REQ-026 With MAX_FRAMES = N > 0, SHALL go to IDLE after N frames completed since the last start.
REQ-027 underflow SHALL set when byte_sel = 3, out_ready = 1 and c4_valid = 0 in RUN or FINISH; it clears only on rst.
REQ-028 busy SHALL be 1 in RUN and FINISH.
REQ-029 out_valid, c4_rd and the pulse outputs SHALL be 0 in IDLE.
REQ-030 If en and a frame end coincide with en = 0, SHALL end in IDLE with no frame_start pulse.

Reset
REQ-031 rst SHALL force IDLE; row, col, poh_idx, frame_cnt, all pulse outputs, underflow, busy and c4_rd SHALL be 0, and byte_sel SHALL be 0.
REQ-032 rst mid-frame SHALL abandon the frame without a frame_done pulse; it takes priority over en.

Structure
REQ-033 param_pkg SHALL hold:
- the byte_sel enum typedef;
- SOH_COLS = 9, POH_COL = 9, PTR_ROW = 3;
- the state enum.
It SHALL reuse the existing STM1_Length, STM1_Width and c4_Length constants.
REQ-034 The row/column wrap counter SHALL be a sub-module named stm1_pos_counter, with inputs clk, rst, clr and adv, and outputs row, col and last.

Verification
REQ-035 en = 1, out_ready = 1, c4_valid = 1 held: frame_done every 2430 cycles; 2340 c4_rd pulses per frame; frame_start one cycle after frame_done.
REQ-036 Slot-class check: at row 3 cols 0..8, byte_sel = 1; at (0, 9), byte_sel = 2 with poh_idx 0; at (8, 9), poh_idx = 8; at (4, 10), byte_sel = 3.
REQ-037 c4_valid = 0 for 5 cycles at (2, 50) with out_ready = 1: position holds, c4_rd = 0, underflow = 1; it resumes when c4_valid returns.
REQ-038 out_ready = 0 at (0, 3): position frozen and c4_rd = 0; the 9 SOH slots still total 9 accepts.
REQ-039 en dropped at (5, 100): frame completes, frame_done pulses, IDLE follows, frame_cnt increments by 1.
REQ-040 MAX_FRAMES = 2 and rst asserted at (7, 200) of a later run: 2 frames then IDLE; after rst, all outputs are 0 with no frame_done.
